// File: rtl/cfg_chain_loader.sv
// Serial configuration loader: accepts words on a valid/ready stream and shifts
// exactly CHAIN_LEN bits, LSB first, into the daisy-chained config registers.
module cfg_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 20,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_out,
    output logic              cfg_en,
    output logic              busy,
    output logic              done
);

    // Sized one bit wider than strictly needed so the increment on the last
    // bit of a word never wraps.
    localparam int WC_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    // The chain-length limit takes priority over the word boundary, so any
    // unshifted bits of a partial last word are dropped.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bit_cnt_d = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    shreg_d    = in_data;
                    word_cnt_d = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d    = {1'b0, shreg_q[WORD_W-1:1]};
                word_cnt_d = word_cnt_q + 1'b1;
                bit_cnt_d  = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                    state_d = DONE;
                end else if (word_cnt_q == WC_W'(WORD_W - 1)) begin
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == LOAD);
    assign cfg_en   = (state_q == SHIFT);
    assign cfg_out  = (state_q == SHIFT) & shreg_q[0];
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader: expected chain bits are queued when
// words are driven and popped as the loader emits cfg_en pulses.
module tb_cfg_chain_loader;

    localparam int WORD_W    = 8;
    localparam int CHAIN_LEN = 20;
    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BOUND     = 200;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              cfg_out;
    logic              cfg_en;
    logic              busy;
    logic              done;

    int   checks;
    int   failures;
    int   cycCnt;
    int   cfgCount;
    int   doneCount;
    int   acceptCount;
    bit   checkBits;
    logic expQ[$];

    cfg_chain_loader #(
        .WORD_W   (WORD_W),
        .CHAIN_LEN(CHAIN_LEN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .cfg_out (cfg_out),
        .cfg_en  (cfg_en),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycCnt = cycCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Inputs only change at posedge+1, so values seen here are what the next edge will use.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) acceptCount = acceptCount + 1;
            if (done) doneCount = doneCount + 1;
            if (cfg_en) begin
                cfgCount = cfgCount + 1;
                if (checkBits) begin
                    if (expQ.size() == 0) checkOutput("bit_extra", 32'(cfg_en), 32'd0);
                    else checkOutput("bit", 32'(cfg_out), 32'(expQ.pop_front()));
                end
            end
        end
    end

    task automatic waitReady(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput(tag, 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                                 input logic [WORD_W-1:0] w2, input int stall,
                                 input bit pokeStart, input bit extraWord);
        logic [WORD_W-1:0] words[NWORDS];
        int nBits, startCyc, baseCfg, baseDone, baseAcc, n;
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        nBits = 0;
        for (int i = 0; i < NWORDS; i++) begin
            for (int b = 0; b < WORD_W; b++) begin
                if (nBits < CHAIN_LEN) begin
                    expQ.push_back(words[i][b]);
                    nBits++;
                end
            end
        end
        baseCfg  = cfgCount;
        baseDone = doneCount;
        baseAcc  = acceptCount;

        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        startCyc = cycCnt;
        start    = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("ready_after_start", 32'(in_ready), 32'd1);

        for (int i = 0; i < NWORDS; i++) begin
            in_data  = words[i];
            in_valid = !(i == 1 && stall > 0);
            waitReady("timeout_ready");
            if (i == 1 && stall > 0) begin
                for (int s = 0; s < stall; s++) begin
                    @(posedge clk); #1;
                    checkOutput("stall_no_en", 32'(cfg_en), 32'd0);
                end
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            if (i == 0 && pokeStart) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        if (extraWord) begin
            in_data  = 8'hAA;
            in_valid = 1'b1;
        end else begin
            in_valid = 1'b0;
        end

        n = 0;
        @(negedge clk);
        while (!done && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_seen", 32'(done), 32'd1);
        checkOutput("latency", 32'(cycCnt - startCyc), 32'(CHAIN_LEN + NWORDS + stall));
        @(negedge clk);
        checkOutput("done_pulse", 32'(done), 32'd0);
        checkOutput("busy_idle", 32'(busy), 32'd0);
        checkOutput("ready_idle", 32'(in_ready), 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("ready_extra", 32'(in_ready), 32'd0);
        checkOutput("bit_count", 32'(cfgCount - baseCfg), 32'(CHAIN_LEN));
        checkOutput("done_count", 32'(doneCount - baseDone), 32'd1);
        checkOutput("accept_count", 32'(acceptCount - baseAcc), 32'(NWORDS));
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        checks      = 0;
        failures    = 0;
        cycCnt      = 0;
        cfgCount    = 0;
        doneCount   = 0;
        acceptCount = 0;
        checkBits   = 1'b1;
        rst_n       = 1'b0;
        start       = 1'b1;
        in_valid    = 1'b1;
        in_data     = 8'h5A;

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", 32'({in_ready, cfg_out, cfg_en, busy, done}), 32'd0);
        start    = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_reset_ready", 32'(in_ready), 32'd0);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);

        $display("[TB] basic load");
        applyStimulus(8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 1'b0);
        $display("[TB] stalled source");
        applyStimulus(8'hA5, 8'h3C, 8'h0F, 5, 1'b0, 1'b0);
        $display("[TB] truncated last word");
        applyStimulus(8'h00, 8'h00, 8'hFF, 0, 1'b0, 1'b1);
        $display("[TB] start during shift");
        applyStimulus(8'h96, 8'hC3, 8'h5A, 0, 1'b1, 1'b0);

        // Abort a load partway through with an asynchronous reset.
        $display("[TB] reset mid-load");
        checkBits = 1'b0;
        n = cfgCount;
        @(posedge clk); #1;
        start    = 1'b1;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < BOUND && (cfgCount - n) < 10; k++) @(negedge clk);
        checkOutput("abort_reached", 32'(cfgCount - n >= 10), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", 32'({in_ready, cfg_out, cfg_en, busy, done}), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expQ.delete();
        checkBits = 1'b1;
        applyStimulus(8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
